// File: rtl/cpu_pkg.sv
// Shared types for multicycle_cpu: opcode and FSM state enums plus the
// instruction field layout {opcode, rd, rs, imm}, MSB first.
package cpu_pkg;

  localparam int OPC_W   = 4;
  localparam int IMM_LSB = 0;

  function automatic int rsLsb(input int dataWidth);
    return dataWidth;
  endfunction

  function automatic int rdLsb(input int dataWidth, input int addrBits);
    return dataWidth + addrBits;
  endfunction

  function automatic int opcLsb(input int dataWidth, input int addrBits);
    return dataWidth + 2 * addrBits;
  endfunction

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_NOT  = 4'd6,
    OP_SHL  = 4'd7,
    OP_SHR  = 4'd8,
    OP_ADDI = 4'd9,
    OP_SUBI = 4'd10,
    OP_LDI  = 4'd11,
    OP_MOV  = 4'd12,
    OP_CMP  = 4'd13,
    OP_OUT  = 4'd14,
    OP_ILL  = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_EXEC,
    S_WB
  } state_e;

  // Opcodes that need a second register read (R[rs]) before execute.
  function automatic logic needsOperandB(input opcode_e op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV, OP_CMP};
  endfunction

  function automatic logic writesReg(input opcode_e op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL,
                      OP_SHR, OP_ADDI, OP_SUBI, OP_LDI, OP_MOV};
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Register file for multicycle_cpu: one synchronous read port, one write port,
// asynchronous active-low clear of every entry.
module cpu_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_BITS-1:0]  raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  input  logic                  we_i,
  input  logic [ADDR_BITS-1:0]  waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read samples the old contents, so a same-cycle write is not forwarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle CPU: accepts one instruction over valid/ready and sequences it
// through RD_A/RD_B/EXEC/WB. Define CPU_SAT_EN for saturating ADD/ADDI/SUB/SUBI.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter  int DATA_WIDTH  = 8,
  parameter  int ADDR_BITS   = 5,
  localparam int INSTR_WIDTH = OPC_W + 2 * ADDR_BITS + DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  input  logic                   instr_valid_i,
  output logic                   instr_ready_o,
  output logic [DATA_WIDTH-1:0]  result_o,
  output logic                   result_valid_o,
  output logic                   zero_o,
  output logic                   carry_o,
  output logic                   illegal_o,
  output logic                   busy_o
);

  localparam int RS_LSB  = rsLsb(DATA_WIDTH);
  localparam int RD_LSB  = rdLsb(DATA_WIDTH, ADDR_BITS);
  localparam int OPC_LSB = opcLsb(DATA_WIDTH, ADDR_BITS);

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0]  opA_q, exRes_q, result_q;
  logic                   exCarry_q, zero_q, carry_q;

  opcode_e                opcode, opcodeIn;
  logic [ADDR_BITS-1:0]   rdAddr, rsAddr, rfRaddr;
  logic [DATA_WIDTH-1:0]  imm, rfRdata, aluA, aluB, aluRes;
  logic [DATA_WIDTH:0]    sum, diff;
  logic                   aluCarry, rfWe, accept;

  assign opcode   = opcode_e'(instr_q[OPC_LSB +: OPC_W]);
  assign opcodeIn = opcode_e'(instr_i[OPC_LSB +: OPC_W]);
  assign rdAddr   = instr_q[RD_LSB +: ADDR_BITS];
  assign rsAddr   = instr_q[RS_LSB +: ADDR_BITS];
  assign imm      = instr_q[IMM_LSB +: DATA_WIDTH];
  assign accept   = (state_q == S_IDLE) && instr_valid_i;

  cpu_regfile #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr_i(rfRaddr),
    .rdata_o(rfRdata),
    .we_i   (rfWe),
    .waddr_i(rdAddr),
    .wdata_i(exRes_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (instr_valid_i) state_d = (opcodeIn == OP_LDI) ? S_EXEC : S_RD_A;
      S_RD_A:  state_d = needsOperandB(opcode) ? S_RD_B : S_EXEC;
      S_RD_B:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // rd is read in RD_A, rs in RD_B; each read lands one cycle later.
  always_comb begin
    instr_ready_o  = 1'b0;
    busy_o         = 1'b1;
    result_valid_o = 1'b0;
    illegal_o      = 1'b0;
    rfWe           = 1'b0;
    rfRaddr        = rdAddr;
    case (state_q)
      S_IDLE: begin
        instr_ready_o = 1'b1;
        busy_o        = 1'b0;
      end
      S_RD_B: rfRaddr = rsAddr;
      S_WB: begin
        result_valid_o = 1'b1;
        illegal_o      = (opcode == OP_ILL);
        rfWe           = writesReg(opcode);
      end
      default: ;
    endcase
  end

  assign aluA = needsOperandB(opcode) ? opA_q : rfRdata;
  assign aluB = (opcode == OP_ADDI || opcode == OP_SUBI) ? imm : rfRdata;
  assign sum  = {1'b0, aluA} + {1'b0, aluB};
  assign diff = {1'b0, aluA} - {1'b0, aluB};

  always_comb begin
    aluRes   = '0;
    aluCarry = 1'b0;
    case (opcode)
      OP_ADD, OP_ADDI: begin
        aluCarry = sum[DATA_WIDTH];
`ifdef CPU_SAT_EN
        aluRes   = sum[DATA_WIDTH] ? '1 : sum[DATA_WIDTH-1:0];
`else
        aluRes   = sum[DATA_WIDTH-1:0];
`endif
      end
      OP_SUB, OP_SUBI: begin
        aluCarry = diff[DATA_WIDTH];
`ifdef CPU_SAT_EN
        aluRes   = diff[DATA_WIDTH] ? '0 : diff[DATA_WIDTH-1:0];
`else
        aluRes   = diff[DATA_WIDTH-1:0];
`endif
      end
      OP_CMP: begin
        aluRes   = diff[DATA_WIDTH-1:0];
        aluCarry = diff[DATA_WIDTH];
      end
      OP_AND: aluRes = aluA & aluB;
      OP_OR:  aluRes = aluA | aluB;
      OP_XOR: aluRes = aluA ^ aluB;
      OP_NOT: aluRes = ~aluA;
      OP_SHL: begin
        aluRes   = {aluA[DATA_WIDTH-2:0], 1'b0};
        aluCarry = aluA[DATA_WIDTH-1];
      end
      OP_SHR: begin
        aluRes   = {1'b0, aluA[DATA_WIDTH-1:1]};
        aluCarry = aluA[0];
      end
      OP_LDI: aluRes = imm;
      OP_MOV: aluRes = aluB;
      OP_OUT: aluRes = aluA;
      default: ;
    endcase
  end

  // CMP only touches flags, OUT only touches result_o; NOP and illegal touch neither.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q   <= '0;
      opA_q     <= '0;
      exRes_q   <= '0;
      exCarry_q <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      if (accept) instr_q <= instr_i;
      if (state_q == S_RD_B) opA_q <= rfRdata;
      if (state_q == S_EXEC) begin
        exRes_q   <= aluRes;
        exCarry_q <= aluCarry;
      end
      if (state_q == S_WB && opcode != OP_NOP && opcode != OP_ILL) begin
        if (opcode != OP_CMP) result_q <= exRes_q;
        if (opcode != OP_OUT) begin
          zero_q  <= (exRes_q == '0);
          carry_q <= exCarry_q;
        end
      end
    end
  end

  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign carry_o  = carry_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed self-checking bench for multicycle_cpu with hand-computed expectations;
// expectations follow CPU_SAT_EN when it is defined for the build.
module tb_multicycle_cpu;

  localparam logic [3:0] OPC_NOP  = 4'd0;
  localparam logic [3:0] OPC_ADD  = 4'd1;
  localparam logic [3:0] OPC_SUB  = 4'd2;
  localparam logic [3:0] OPC_AND  = 4'd3;
  localparam logic [3:0] OPC_OR   = 4'd4;
  localparam logic [3:0] OPC_XOR  = 4'd5;
  localparam logic [3:0] OPC_NOT  = 4'd6;
  localparam logic [3:0] OPC_SHL  = 4'd7;
  localparam logic [3:0] OPC_SHR  = 4'd8;
  localparam logic [3:0] OPC_ADDI = 4'd9;
  localparam logic [3:0] OPC_SUBI = 4'd10;
  localparam logic [3:0] OPC_LDI  = 4'd11;
  localparam logic [3:0] OPC_MOV  = 4'd12;
  localparam logic [3:0] OPC_CMP  = 4'd13;
  localparam logic [3:0] OPC_OUT  = 4'd14;
  localparam logic [3:0] OPC_ILL  = 4'd15;

`ifdef CPU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [21:0] instr_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [7:0]  result_o;
  logic        result_valid_o;
  logic        zero_o;
  logic        carry_o;
  logic        illegal_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_cpu #(
    .DATA_WIDTH(8),
    .ADDR_BITS (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_i       (instr_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .result_o      (result_o),
    .result_valid_o(result_valid_o),
    .zero_o        (zero_o),
    .carry_o       (carry_o),
    .illegal_o     (illegal_o),
    .busy_o        (busy_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  // Issues one instruction, checks the result_valid_o timing against the
  // expected latency, then checks the committed state; x expectations skip.
  task automatic applyStimulus(input string tag, input logic [3:0] op,
                               input logic [4:0] rd, input logic [4:0] rs,
                               input logic [7:0] imm, input int latency,
                               input logic [7:0] expRes, input logic expZero,
                               input logic expCarry);
    int waitCnt = 0;
    @(negedge clk);
    while (!instr_ready_o && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput({tag, "/readyBefore"}, instr_ready_o, 1);
    instr_i       = {op, rd, rs, imm};
    instr_valid_i = 1'b1;
    @(posedge clk);
    #1;
    instr_valid_i = 1'b0;
    instr_i       = '0;
    checkOutput({tag, "/busy"}, busy_o, 1);
    checkOutput({tag, "/readyBusy"}, instr_ready_o, 0);
    for (int i = 1; i < latency; i++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "/resultValid"}, result_valid_o, (i == latency - 1));
    end
    checkOutput({tag, "/illegalWb"}, illegal_o, (op == OPC_ILL));
    @(posedge clk);
    #1;
    checkOutput({tag, "/readyAfter"}, instr_ready_o, 1);
    checkOutput({tag, "/resultValidAfter"}, result_valid_o, 0);
    checkOutput({tag, "/illegalAfter"}, illegal_o, 0);
    if (!$isunknown(expRes))   checkOutput({tag, "/result"}, result_o, expRes);
    if (!$isunknown(expZero))  checkOutput({tag, "/zero"}, zero_o, expZero);
    if (!$isunknown(expCarry)) checkOutput({tag, "/carry"}, carry_o, expCarry);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst           = 1'b0;
    instr_valid_i = 1'b0;
    instr_i       = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset/result", result_o, 8'h00);
    checkOutput("reset/zero", zero_o, 0);
    checkOutput("reset/carry", carry_o, 0);
    checkOutput("reset/busy", busy_o, 0);
    checkOutput("reset/resultValid", result_valid_o, 0);
    checkOutput("reset/illegal", illegal_o, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset/readyAfterDeassert", instr_ready_o, 1);

    applyStimulus("ldiR1_05", OPC_LDI, 5'd1, 5'd0, 8'h05, 2, 8'h05, 1'b0, 1'b0);
    applyStimulus("outR1",    OPC_OUT, 5'd1, 5'd0, 8'h00, 3, 8'h05, 1'b0, 1'b0);
    applyStimulus("ldiR1_F0", OPC_LDI, 5'd1, 5'd0, 8'hF0, 2, 8'hF0, 1'b0, 1'b0);
    applyStimulus("ldiR2_20", OPC_LDI, 5'd2, 5'd0, 8'h20, 2, 8'h20, 1'b0, 1'b0);
    applyStimulus("addR1R2",  OPC_ADD, 5'd1, 5'd2, 8'h00, 4, SAT ? 8'hFF : 8'h10, 1'b0, 1'b1);
    applyStimulus("ldiR3_07", OPC_LDI, 5'd3, 5'd0, 8'h07, 2, 8'h07, 1'b0, 1'bx);
    applyStimulus("subR3R3",  OPC_SUB, 5'd3, 5'd3, 8'h00, 4, 8'h00, 1'b1, 1'b0);
    applyStimulus("cmpR3R1",  OPC_CMP, 5'd3, 5'd1, 8'h00, 4, 8'hxx, 1'b0, 1'b1);
    applyStimulus("outR3",    OPC_OUT, 5'd3, 5'd0, 8'h00, 3, 8'h00, 1'b0, 1'b1);

    applyStimulus("ldiR4_81", OPC_LDI, 5'd4, 5'd0, 8'h81, 2, 8'h81, 1'b0, 1'bx);
    applyStimulus("shlR4",    OPC_SHL, 5'd4, 5'd0, 8'h00, 3, 8'h02, 1'b0, 1'b1);
    applyStimulus("ldiR5_01", OPC_LDI, 5'd5, 5'd0, 8'h01, 2, 8'h01, 1'b0, 1'bx);
    applyStimulus("shrR5",    OPC_SHR, 5'd5, 5'd0, 8'h00, 3, 8'h00, 1'b1, 1'b1);
    applyStimulus("nop",      OPC_NOP, 5'd0, 5'd0, 8'h00, 3, 8'h00, 1'b1, 1'b1);

    applyStimulus("ldiR6_3C", OPC_LDI,  5'd6, 5'd0, 8'h3C, 2, 8'h3C, 1'b0, 1'bx);
    applyStimulus("addiR6",   OPC_ADDI, 5'd6, 5'd0, 8'hD0, 3, SAT ? 8'hFF : 8'h0C, 1'b0, 1'b1);
    applyStimulus("xorR6R4",  OPC_XOR,  5'd6, 5'd4, 8'h00, 4, SAT ? 8'hFD : 8'h0E, 1'b0, 1'b0);
    applyStimulus("andR6R4",  OPC_AND,  5'd6, 5'd4, 8'h00, 4, SAT ? 8'h00 : 8'h02, SAT, 1'b0);
    applyStimulus("orR6R2",   OPC_OR,   5'd6, 5'd2, 8'h00, 4, SAT ? 8'h20 : 8'h22, 1'b0, 1'b0);
    applyStimulus("notR6",    OPC_NOT,  5'd6, 5'd0, 8'h00, 3, SAT ? 8'hDF : 8'hDD, 1'b0, 1'b0);
    applyStimulus("subiR6",   OPC_SUBI, 5'd6, 5'd0, 8'hE0, 3, SAT ? 8'h00 : 8'hFD, SAT, 1'b1);
    applyStimulus("movR7R6",  OPC_MOV,  5'd7, 5'd6, 8'h00, 4, SAT ? 8'h00 : 8'hFD, SAT, 1'bx);
    applyStimulus("outR7",    OPC_OUT,  5'd7, 5'd0, 8'h00, 3, SAT ? 8'h00 : 8'hFD, SAT, 1'bx);

    // valid held high through a busy instruction while instr_i keeps changing
    @(negedge clk);
    checkOutput("hold/readyBefore", instr_ready_o, 1);
    instr_i       = {OPC_LDI, 5'd8, 5'd0, 8'h11};
    instr_valid_i = 1'b1;
    @(posedge clk);
    #1;
    instr_i = {OPC_LDI, 5'd8, 5'd0, 8'h99};
    checkOutput("hold/readyExec", instr_ready_o, 0);
    checkOutput("hold/busyExec", busy_o, 1);
    @(posedge clk);
    #1;
    instr_i = {OPC_LDI, 5'd8, 5'd0, 8'h77};
    checkOutput("hold/readyWb", instr_ready_o, 0);
    checkOutput("hold/resultValidWb", result_valid_o, 1);
    @(posedge clk);
    #1;
    instr_valid_i = 1'b0;
    instr_i       = '0;
    checkOutput("hold/readyAfterWb", instr_ready_o, 1);
    checkOutput("hold/result", result_o, 8'h11);
    applyStimulus("outR8",     OPC_OUT, 5'd8, 5'd0, 8'h00, 3, 8'h11, 1'b0, 1'bx);

    applyStimulus("illegal",   OPC_ILL, 5'd8, 5'd8, 8'h55, 3, 8'h11, 1'b0, 1'bx);
    applyStimulus("outR8Post", OPC_OUT, 5'd8, 5'd0, 8'h00, 3, 8'h11, 1'b0, 1'bx);

    // reset lands while an ADD sits in RD_B
    applyStimulus("ldiR9_01", OPC_LDI, 5'd9, 5'd0, 8'h01, 2, 8'h01, 1'b0, 1'bx);
    @(negedge clk);
    checkOutput("abort/readyBefore", instr_ready_o, 1);
    instr_i       = {OPC_ADD, 5'd9, 5'd8, 8'h00};
    instr_valid_i = 1'b1;
    @(posedge clk);
    #1;
    instr_valid_i = 1'b0;
    instr_i       = '0;
    @(posedge clk);
    #1;
    checkOutput("abort/busyRdB", busy_o, 1);
    rst = 1'b0;
    #1;
    checkOutput("abort/result", result_o, 8'h00);
    checkOutput("abort/zero", zero_o, 0);
    checkOutput("abort/carry", carry_o, 0);
    checkOutput("abort/busy", busy_o, 0);
    checkOutput("abort/resultValid", result_valid_o, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort/readyAfter", instr_ready_o, 1);
    checkOutput("abort/resultValidAfter", result_valid_o, 0);
    applyStimulus("outR9Abort", OPC_OUT, 5'd9, 5'd0, 8'h00, 3, 8'h00, 1'b0, 1'b0);
    applyStimulus("outR8Abort", OPC_OUT, 5'd8, 5'd0, 8'h00, 3, 8'h00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
